store_buffer: RTL and testbench

Store-path write buffer between the MEM stage and data memory; the write-direction counterpart of the load/immediate extenders. It takes store requests (sw/sh/sb) carrying raw register data and an unaligned byte address. It packs each into a word-aligned address, a 4-bit byte enable and lane-replicated write data, and queues it in a small FIFO. The FIFO drains to the data-memory port over a valid/ready handshake, so memory stalls do not immediately stall the pipeline.

---
 rtl/store_buffer_pkg.sv | 34 +++
 rtl/store_buffer_pack.sv | 42 ++++
 rtl/store_buffer.sv | 91 +++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared memory-path constants: load extender ops, store ops, byte enables.
// Also holds the store-buffer entry layout.
package store_buffer_pkg;

    typedef enum logic [2:0] {
        EXT_LB  = 3'd0,
        EXT_LBU = 3'd1,
        EXT_LH  = 3'd2,
        EXT_LHU = 3'd3,
        EXT_LW  = 3'd4
    } ext_op_e;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_pack.sv
// Store packer: op + low address bits + raw data -> byte enables, lane data.
// Purely combinational; flags misaligned and reserved ops.
module store_pack
    import store_buffer_pkg::*;
(
    input  st_op_e      op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] data,
    output logic        illegal
);

    always_comb begin
        be      = '0;
        data    = wdata;
        illegal = 1'b0;
        unique case (op)
            ST_SW: begin
                be      = BE_WORD;
                illegal = addr_lo != 2'b00;
            end
            ST_SH: begin
                be      = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                data    = {2{wdata[15:0]}};
                illegal = addr_lo[0];
            end
            ST_SB: begin
                data = {4{wdata[7:0]}};
                unique case (addr_lo)
                    2'd0: be = BE_BYTE0;
                    2'd1: be = BE_BYTE1;
                    2'd2: be = BE_BYTE2;
                    2'd3: be = BE_BYTE3;
                    default: be = '0;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store write buffer between MEM and data memory.
// Packs requests and queues them in a small FIFO drained by valid/ready.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    output logic             align_err,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             align_err_q;

    logic [3:0]  pk_be;
    logic [31:0] pk_data;
    logic        pk_illegal;
    logic        take;
    logic        push;
    logic        pop;
    sb_entry_t   new_entry;

    store_pack u_pack (
        .op      (st_op_e'(req_op)),
        .addr_lo (req_addr[1:0]),
        .wdata   (req_wdata),
        .be      (pk_be),
        .data    (pk_data),
        .illegal (pk_illegal)
    );

    assign req_ready = count_q != CNT_W'(DEPTH);
    assign take      = req_valid && req_ready;
    assign push      = take && !pk_illegal;
    assign pop       = mem_valid && mem_ready;

    assign new_entry.addr = {req_addr[31:2], 2'b00};
    assign new_entry.be   = pk_be;
    assign new_entry.data = pk_data;

    // Head storage drives memory directly; no bypass from the request side.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= new_entry;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
            align_err_q <= take && pk_illegal;
        end
    end

    assign mem_valid = count_q != '0;
    assign empty     = count_q == '0;
    assign count     = count_q;
    assign align_err = align_err_q;
    assign mem_addr  = fifo_q[head_q].addr;
    assign mem_be    = fifo_q[head_q].be;
    assign mem_wdata = fifo_q[head_q].data;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed cases then random traffic.
// A queue-based reference model predicts every accepted store.
module tb_store_buffer;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [31:0]      req_addr = '0;
    logic [31:0]      req_wdata = '0;
    logic             mem_valid;
    logic             mem_ready = 1'b0;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic             align_err;
    logic             empty;
    logic [CNT_W-1:0] count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .align_err (align_err),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    logic exp_err = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for a store written from the ISA's point of view.
    function automatic bit is_illegal(input logic [1:0] op, input logic [31:0] a);
        if (op == 2'd3) return 1'b1;
        if (op == 2'd0) return (a % 4) != 0;
        if (op == 2'd1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t e;
        int lane;
        lane   = a % 4;
        e.addr = a - lane;
        if (op == 2'd0) begin
            e.be   = 4'hF;
            e.data = d;
        end else if (op == 2'd1) begin
            e.be   = (lane >= 2) ? 4'hC : 4'h3;
            e.data = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.be   = 4'(1 << lane);
            e.data = (d & 32'hFF) * 32'h0101_0101;
        end
        return e;
    endfunction

    // Monitor: compare against model, then predict the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            exp_err = 1'b0;
            chk("rst_count", 32'(count), 0);
            chk("rst_empty", 32'(empty), 1);
            chk("rst_req_ready", 32'(req_ready), 1);
            chk("rst_mem_valid", 32'(mem_valid), 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_be", 32'(mem_be), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_align_err", 32'(align_err), 0);
        end else begin
            int  sz;
            bit  acc;
            bit  ill;
            sz = q.size();
            chk("count", 32'(count), 32'(sz));
            chk("empty", 32'(empty), 32'(sz == 0));
            chk("req_ready", 32'(req_ready), 32'(sz != DEPTH));
            chk("mem_valid", 32'(mem_valid), 32'(sz != 0));
            chk("align_err", 32'(align_err), 32'(exp_err));
            if (sz != 0) begin
                chk("mem_addr", mem_addr, q[0].addr);
                chk("mem_be", 32'(mem_be), 32'(q[0].be));
                chk("mem_wdata", mem_wdata, q[0].data);
            end
            acc = req_valid && (sz != DEPTH);
            ill = is_illegal(req_op, req_addr);
            if (sz != 0 && mem_ready) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (acc && !ill) q.push_back(model(req_op, req_addr, req_wdata));
            exp_err = acc && ill;
        end
    end

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic mr);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mr, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 32'h0, 32'h0, mr);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(1'b1, 1);

        // Legal packing cases from the plan.
        drive(1'b1, 2'd0, 32'h0000_1004, 32'h1234_5678, 1'b1);
        idle(1'b1, 2);
        drive(1'b1, 2'd1, 32'h0000_2002, 32'hAAAA_BEEF, 1'b1);
        drive(1'b1, 2'd2, 32'h0000_3003, 32'h0000_0055, 1'b1);
        idle(1'b1, 2);

        // Illegal requests: consumed, flagged, never queued.
        drive(1'b1, 2'd0, 32'h0000_4001, 32'hDEAD_0001, 1'b1);
        idle(1'b1, 1);
        drive(1'b1, 2'd1, 32'h0000_4003, 32'hDEAD_0002, 1'b1);
        idle(1'b1, 1);
        drive(1'b1, 2'd3, 32'h0000_4000, 32'hDEAD_0003, 1'b1);
        drive(1'b1, 2'd3, 32'h0000_4004, 32'hDEAD_0004, 1'b1);
        idle(1'b1, 2);

        // Full buffer with memory stalled; third store held.
        drive(1'b1, 2'd0, 32'h0000_5000, 32'h1111_1111, 1'b0);
        drive(1'b1, 2'd0, 32'h0000_5004, 32'h2222_2222, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 2'd0, 32'h0000_5008, 32'h3333_3333, 1'b0);
        drive(1'b1, 2'd0, 32'h0000_5008, 32'h3333_3333, 1'b1);
        drive(1'b1, 2'd0, 32'h0000_5008, 32'h3333_3333, 1'b0);
        idle(1'b1, 4);

        // Steady push+pop at count=1, then reset mid-burst.
        drive(1'b1, 2'd2, 32'h0000_6000, 32'h0000_00A0, 1'b1);
        for (int i = 1; i < 9; i++)
            drive(1'b1, 2'd2, 32'h0000_6000 + 32'(i), 32'(8'hA0 + i), 1'b1);
        drive(1'b1, 2'd0, 32'h0000_7000, 32'h7777_7777, 1'b0);
        drive(1'b1, 2'd0, 32'h0000_7004, 32'h7777_7778, 1'b0);
        reset = 1'b0;
        idle(1'b1, 2);
        reset = 1'b1;
        idle(1'b1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                  $urandom, 1'($urandom_range(0, 2) != 0));
        end
        idle(1'b1, 6);

        n_checks++;
        if (n_pops < 20) begin
            n_errors++;
            $display("FAIL drain_activity: got %0d pops expected at least 20", n_pops);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
